// File: rtl/uart_loopback_core.sv
// rtl/uart_loopback_core.sv - 8N1 UART receiver and transmitter with one-byte holding buffer and rx->tx loopback
module uart_loopback_core #(
    parameter int scaler = 8
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_rx,
    output logic       o_tx,
    input  logic       i_loopback_ena,
    output logic       o_rx_rdy,
    output logic [7:0] o_rx_data,
    output logic       o_tx_full
);
    localparam int BP = 2 * scaler;
    localparam int CW = $clog2(BP);
    localparam logic [CW-1:0] BP_LAST   = CW'(BP - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(scaler - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    // receiver state
    logic          rx_meta_q, rx_sync_q;
    state_t        rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_ferr_q, rx_ferr_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_rdy_q, rx_rdy_d;
    logic          rx_done;

    // transmitter state
    state_t        tx_state_q, tx_state_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [7:0]    tx_buf_q, tx_buf_d;
    logic          tx_full_q, tx_full_d;
    logic          tx_q, tx_d;
    logic          tx_load;
    logic          tx_accept;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 1'b1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_ferr_d  = rx_ferr_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (!rx_sync_q) begin
                    rx_state_d = ST_START;
                    rx_bit_d   = '0;
                end
            end
            ST_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = rx_sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt_q == BP_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                // after a framing error, hold here until the line is idle again
                if (rx_ferr_q) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_ferr_d  = 1'b0;
                        rx_state_d = ST_IDLE;
                    end
                end else if (rx_cnt_q == BP_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_done    = 1'b1;
                        rx_state_d = ST_IDLE;
                    end else begin
                        rx_ferr_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // rdy is sticky while the holding buffer is full; a new byte overwrites the old one
    always_comb begin
        rx_data_d = rx_data_q;
        rx_rdy_d  = rx_rdy_q & tx_full_q;
        if (rx_done) begin
            rx_data_d = rx_shift_q;
            rx_rdy_d  = 1'b1;
        end
    end

    assign tx_accept = rx_rdy_q & i_loopback_ena & ~tx_full_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q + 1'b1;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_load    = 1'b0;
        case (tx_state_q)
            ST_IDLE: begin
                tx_cnt_d = '0;
                tx_load  = tx_full_q;
            end
            ST_START: begin
                if (tx_cnt_q == BP_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tx_cnt_q == BP_LAST) begin
                    tx_cnt_d = '0;
                    tx_bit_d = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) begin
                        tx_d       = 1'b1;
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tx_cnt_q == BP_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_IDLE;
                    tx_load    = tx_full_q;
                end
            end
        endcase
        // a waiting byte starts its start bit straight out of idle or the previous stop bit
        if (tx_load) begin
            tx_state_d = ST_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_buf_q;
            tx_d       = 1'b0;
        end
    end

    always_comb begin
        tx_buf_d  = tx_buf_q;
        tx_full_d = tx_full_q;
        if (tx_load) begin
            tx_full_d = 1'b0;
        end else if (tx_accept) begin
            tx_buf_d  = rx_data_q;
            tx_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_ferr_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_rdy_q   <= 1'b0;
            tx_state_q <= ST_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            rx_meta_q  <= i_rx;
            rx_sync_q  <= rx_meta_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_ferr_q  <= rx_ferr_d;
            rx_data_q  <= rx_data_d;
            rx_rdy_q   <= rx_rdy_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_buf_q   <= tx_buf_d;
            tx_full_q  <= tx_full_d;
            tx_q       <= tx_d;
        end
    end

    assign o_tx      = tx_q;
    assign o_rx_rdy  = rx_rdy_q;
    assign o_rx_data = rx_data_q;
    assign o_tx_full = tx_full_q;

endmodule

// File: tb/tb_uart_loopback_core.sv
// tb/tb_uart_loopback_core.sv - scoreboard bench for uart_loopback_core
module tb_uart_loopback_core;
    localparam int SCALER = 8;
    localparam int BP     = 2 * SCALER;

    logic       clk  = 1'b0;
    logic       nrst = 1'b0;
    logic       rx   = 1'b1;
    logic       lb   = 1'b0;
    logic       tx;
    logic       rdy;
    logic       full;
    logic [7:0] data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];
    bit rx_mon_en  = 1'b0;
    bit tx_mon_en  = 1'b0;
    bit allow_loss = 1'b0;
    int full_rises = 0;
    int tx_low     = 0;
    int hold_seen  = 0;
    int bad_fall   = 0;
    int rdy_rises  = 0;
    int lost       = 0;

    uart_loopback_core #(.scaler(SCALER)) dut (
        .i_clk          (clk),
        .i_nrst         (nrst),
        .i_rx           (rx),
        .o_tx           (tx),
        .i_loopback_ena (lb),
        .o_rx_rdy       (rdy),
        .o_rx_data      (data),
        .o_tx_full      (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len);
        rx = 1'b0;
        repeat (BP) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BP) @(negedge clk);
        end
        rx = stop;
        repeat (stop_len) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic tx_timing(input logic [7:0] b);
        logic [9:0] bits;
        int t;
        bits = {1'b1, b, 1'b0};
        t = 0;
        while (!rdy && t < 40 * BP) begin
            @(negedge clk);
            t++;
        end
        chk("t1_rdy_seen", 32'(rdy), 32'd1);
        if (rdy) begin
            @(negedge clk);
            chk("t1_tx_idle_at_s1", 32'(tx), 32'd1);
            for (int k = 0; k < 10; k++) begin
                for (int c = 0; c < BP; c++) begin
                    @(negedge clk);
                    if (c == 0 || c == BP - 1)
                        chk($sformatf("t1_tx_bit%0d_clk%0d", k, c), 32'(tx), 32'(bits[k]));
                end
            end
        end
    endtask

    // status monitor: rx-side scoreboard and handshake observations
    initial begin : status_mon
        logic rdy_p;
        logic full_p;
        int   rdy_w;
        rdy_p  = 1'b0;
        full_p = 1'b0;
        rdy_w  = 0;
        forever begin
            @(negedge clk);
            if (nrst) begin
                if (full && !full_p) full_rises++;
                if (!tx) tx_low++;
                if (rdy_p && full_p && rdy) hold_seen++;
                if (rdy_p && full_p && !rdy) bad_fall++;
                if (rdy && !rdy_p) begin
                    rdy_rises++;
                    if (rx_mon_en) begin
                        if (exp_rx.size() == 0) chk("rx_unexpected", 32'(data), 32'h100);
                        else chk("rx_data", 32'(data), 32'(exp_rx.pop_front()));
                    end
                end
                if (rdy) begin
                    rdy_w++;
                end else begin
                    if (rdy_p && rx_mon_en) chk("rx_rdy_width", 32'(rdy_w), 32'd1);
                    rdy_w = 0;
                end
            end
            rdy_p  = rdy;
            full_p = full;
        end
    end

    // tx decoder: samples o_tx mid-bit and pops the expected-byte queue
    initial begin : tx_mon
        logic [7:0] d;
        forever begin
            @(negedge clk);
            if (nrst && !tx) begin
                repeat (SCALER - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (BP) @(negedge clk);
                    d[i] = tx;
                end
                repeat (BP) @(negedge clk);
                if (tx_mon_en) begin
                    chk("tx_stop_bit", 32'(tx), 32'd1);
                    if (allow_loss) begin
                        while (exp_tx.size() > 1 && exp_tx[0] != d) begin
                            $display("note: overrun lost byte 0x%02h", exp_tx[0]);
                            void'(exp_tx.pop_front());
                            lost++;
                        end
                    end
                    if (exp_tx.size() == 0) chk("tx_unexpected", 32'(d), 32'h100);
                    else chk("tx_data", 32'(d), 32'(exp_tx.pop_front()));
                end
            end
        end
    end

    initial begin : main
        int f0, t0, r0, h0, t;

        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx), 32'd1);
        chk("reset_rdy", 32'(rdy), 32'd0);
        chk("reset_data", 32'(data), 32'h00);
        chk("reset_full", 32'(full), 32'd0);
        nrst = 1'b1;
        repeat (5) @(negedge clk);
        rx_mon_en = 1'b1;
        tx_mon_en = 1'b1;

        // single byte loopback with exact output timing
        lb = 1'b1;
        exp_rx.push_back(8'h55);
        exp_tx.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1, BP);
            tx_timing(8'h55);
        join
        repeat (4) @(negedge clk);
        chk("t1_rx_queue_empty", 32'(exp_rx.size()), 32'd0);
        chk("t1_tx_queue_empty", 32'(exp_tx.size()), 32'd0);

        // back-to-back frames
        f0 = full_rises;
        exp_rx.push_back(8'h0D); exp_tx.push_back(8'h0D);
        exp_rx.push_back(8'h0A); exp_tx.push_back(8'h0A);
        send_frame(8'h0D, 1'b1, BP);
        send_frame(8'h0A, 1'b1, BP);
        repeat (12 * BP) @(negedge clk);
        chk("t2_rx_queue_empty", 32'(exp_rx.size()), 32'd0);
        chk("t2_tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        chk("t2_full_rises", 32'(full_rises - f0), 32'd2);

        // loopback off
        lb = 1'b0;
        f0 = full_rises; t0 = tx_low; r0 = rdy_rises;
        exp_rx.push_back(8'h41);
        send_frame(8'h41, 1'b1, BP);
        repeat (4 * BP) @(negedge clk);
        chk("t3_rx_queue_empty", 32'(exp_rx.size()), 32'd0);
        chk("t3_rdy_pulses", 32'(rdy_rises - r0), 32'd1);
        chk("t3_data", 32'(data), 32'h41);
        chk("t3_full_never", 32'(full_rises - f0), 32'd0);
        chk("t3_tx_low_cycles", 32'(tx_low - t0), 32'd0);

        // glitch, framing error, then a good frame
        r0 = rdy_rises;
        rx = 1'b0;
        repeat (SCALER - 2) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BP) @(negedge clk);
        chk("t4_glitch_no_rdy", 32'(rdy_rises - r0), 32'd0);
        send_frame(8'hA5, 1'b0, BP);
        repeat (4 * BP) @(negedge clk);
        chk("t4_ferr_no_rdy", 32'(rdy_rises - r0), 32'd0);
        chk("t4_ferr_data_kept", 32'(data), 32'h41);
        exp_rx.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, BP);
        repeat (2 * BP) @(negedge clk);
        chk("t4_good_rdy", 32'(rdy_rises - r0), 32'd1);
        chk("t4_good_data", 32'(data), 32'h3C);
        chk("t4_rx_queue_empty", 32'(exp_rx.size()), 32'd0);

        // overrun: shortened stop bits let rx outpace tx until a byte is overwritten
        rx_mon_en  = 1'b0;
        allow_loss = 1'b1;
        lb = 1'b1;
        h0 = hold_seen;
        lost = 0;
        for (int b = 1; b <= 100; b++) begin
            exp_tx.push_back(8'(b));
            send_frame(8'(b), 1'b1, SCALER + 4);
        end
        repeat (40 * BP) @(negedge clk);
        chk("t5_tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        chk("t5_byte_lost", 32'(lost > 0), 32'd1);
        chk("t5_rdy_held_while_full", 32'(hold_seen > h0), 32'd1);
        chk("t5_rdy_never_drops_while_full", 32'(bad_fall), 32'd0);
        chk("t5_last_data", 32'(data), 32'd100);
        chk("t5_idle_full", 32'(full), 32'd0);

        // asynchronous reset while the holding buffer is occupied
        tx_mon_en  = 1'b0;
        allow_loss = 1'b0;
        fork
            send_frame(8'h5A, 1'b1, BP);
            begin
                t = 0;
                while (!full && t < 40 * BP) begin
                    @(negedge clk);
                    t++;
                end
                chk("t6_full_before_reset", 32'(full), 32'd1);
                #1 nrst = 1'b0;
                #1;
                chk("t6_reset_tx", 32'(tx), 32'd1);
                chk("t6_reset_rdy", 32'(rdy), 32'd0);
                chk("t6_reset_data", 32'(data), 32'h00);
                chk("t6_reset_full", 32'(full), 32'd0);
            end
        join
        repeat (4) @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_after_reset_tx", 32'(tx), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
